// File: rtl/ac_pkg.sv
// ac_pkg: constants and FSM encoding shared by the Aho-Corasick table
// writer, the table reader and the RAM wrappers.
//   STATE_W   - width of a state/node id
//   CHAR_W    - width of a pattern character
//   ADDR_W    - goto RAM address width, address = {state, char}
//   NO_EDGE   - goto entry value meaning "no edge" (root is never a child)
//   ROOT      - root state id
//   MAX_STATE - highest allocatable state id (255 is reserved)
package ac_pkg;

  localparam int STATE_W = 8;
  localparam int CHAR_W  = 4;
  localparam int ADDR_W  = STATE_W + CHAR_W;

  localparam logic [STATE_W-1:0] NO_EDGE     = 8'd0;
  localparam logic [STATE_W-1:0] ROOT        = 8'd0;
  localparam logic [STATE_W-1:0] FIRST_STATE = 8'd1;
  localparam logic [STATE_W-1:0] MAX_STATE   = 8'd254;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_LOOK   = 3'd2,
    ST_DECIDE = 3'd3,
    ST_MARK   = 3'd4
  } ac_state_e;

endpackage

// File: rtl/table_writer.sv
// table_writer: builds the Aho-Corasick goto table and per-state match flags
// from a stream of 4-bit pattern characters. Owns the write ports of the goto
// RAM and the match-flag RAM during load, and clears both on INITIALIZE.
//
// Ports
//   CLK, RST     - clock (rising edge), asynchronous active-low reset
//   INITIALIZE   - starts a full table clear; wins over everything else
//   PAT_VALID/PAT_READY/PAT_CHAR/PAT_LAST - pattern character stream
//   ADDR_G, WE_G, WDATA_G, RDATA_G - goto RAM port (read data 1 cycle late)
//   OUT_WE, OUT_ADDR, OUT_WDATA    - match-flag RAM write port
//   STATE_COUNT  - next free state id (= states in use including root)
//   BUSY         - FSM is not in IDLE
//   FULL         - sticky, an allocation was refused since the last clear
//   DONE         - 1-cycle pulse when a pattern's terminal state is marked
//
// Handshake: a character transfers on a rising edge where PAT_VALID and
// PAT_READY are both high. PAT_READY depends only on the FSM state and
// INITIALIZE, never on PAT_VALID, so the source may hold VALID and data
// steady until the transfer.
module table_writer
  import ac_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  input  logic               INITIALIZE,
  input  logic               PAT_VALID,
  output logic               PAT_READY,
  input  logic [CHAR_W-1:0]  PAT_CHAR,
  input  logic               PAT_LAST,
  output logic [ADDR_W-1:0]  ADDR_G,
  output logic               WE_G,
  output logic [STATE_W-1:0] WDATA_G,
  input  logic [STATE_W-1:0] RDATA_G,
  output logic               OUT_WE,
  output logic [STATE_W-1:0] OUT_ADDR,
  output logic               OUT_WDATA,
  output logic [STATE_W-1:0] STATE_COUNT,
  output logic               BUSY,
  output logic               FULL,
  output logic               DONE
);

  ac_state_e          r_state, w_state_nxt;
  logic [STATE_W-1:0] r_cur, w_cur_nxt;
  logic [STATE_W-1:0] r_next_free, w_next_free_nxt;
  logic [ADDR_W-1:0]  r_counter, w_counter_nxt;
  logic               r_drop, w_drop_nxt;
  logic               r_full, w_full_nxt;
  logic [CHAR_W-1:0]  r_char;
  logic               r_last;
  logic               w_accept;

  assign BUSY        = (r_state != ST_IDLE);
  assign STATE_COUNT = r_next_free;
  assign FULL        = r_full;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= ST_IDLE;
      r_cur       <= ROOT;
      r_next_free <= FIRST_STATE;
      r_counter   <= '0;
      r_drop      <= 1'b0;
      r_full      <= 1'b0;
      r_char      <= '0;
      r_last      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cur       <= w_cur_nxt;
      r_next_free <= w_next_free_nxt;
      r_counter   <= w_counter_nxt;
      r_drop      <= w_drop_nxt;
      r_full      <= w_full_nxt;
      if (w_accept) begin
        r_char <= PAT_CHAR;
        r_last <= PAT_LAST;
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cur_nxt       = r_cur;
    w_next_free_nxt = r_next_free;
    w_counter_nxt   = r_counter;
    w_drop_nxt      = r_drop;
    w_full_nxt      = r_full;
    w_accept        = 1'b0;
    PAT_READY       = 1'b0;
    ADDR_G          = '0;
    WE_G            = 1'b0;
    WDATA_G         = '0;
    OUT_WE          = 1'b0;
    OUT_ADDR        = '0;
    OUT_WDATA       = 1'b0;
    DONE            = 1'b0;

    case (r_state)
      ST_IDLE: begin
        PAT_READY = !INITIALIZE;
        if (PAT_VALID && !INITIALIZE) begin
          w_accept = 1'b1;
          if (r_drop) begin
            // Rest of a refused pattern: swallow it, one cycle per char.
            if (PAT_LAST) begin
              w_drop_nxt = 1'b0;
              w_cur_nxt  = ROOT;
            end
          end else begin
            w_state_nxt = ST_LOOK;
          end
        end
      end

      ST_LOOK: begin
        ADDR_G      = {r_cur, r_char};
        w_state_nxt = ST_DECIDE;
      end

      ST_DECIDE: begin
        ADDR_G      = {r_cur, r_char};
        w_state_nxt = r_last ? ST_MARK : ST_IDLE;
        if (RDATA_G != NO_EDGE) begin
          w_cur_nxt = RDATA_G;
        end else if (r_next_free <= MAX_STATE) begin
          WE_G            = 1'b1;
          WDATA_G         = r_next_free;
          w_cur_nxt       = r_next_free;
          w_next_free_nxt = r_next_free + 1'b1;
        end else begin
          // Out of states. The terminal state would be a truncated prefix,
          // so a refused pattern is never marked. If this was the last
          // character the pattern is over now; otherwise drop the rest.
          w_full_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
          if (r_last) begin
            w_cur_nxt = ROOT;
          end else begin
            w_drop_nxt = 1'b1;
          end
        end
      end

      ST_MARK: begin
        OUT_WE      = 1'b1;
        OUT_ADDR    = r_cur;
        OUT_WDATA   = 1'b1;
        DONE        = 1'b1;
        w_cur_nxt   = ROOT;
        w_state_nxt = ST_IDLE;
      end

      ST_CLEAR: begin
        WE_G   = 1'b1;
        ADDR_G = r_counter;
        // Match RAM has one entry per state, i.e. the first 256 addresses.
        if (r_counter[ADDR_W-1:STATE_W] == '0) begin
          OUT_WE   = 1'b1;
          OUT_ADDR = r_counter[STATE_W-1:0];
        end
        if (r_counter == '1) begin
          w_counter_nxt   = '0;
          w_cur_nxt       = ROOT;
          w_next_free_nxt = FIRST_STATE;
          w_full_nxt      = 1'b0;
          w_drop_nxt      = 1'b0;
          w_state_nxt     = ST_IDLE;
        end else begin
          w_counter_nxt = r_counter + 1'b1;
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase

    // INITIALIZE overrides whatever the current state decided, including
    // restarting a clear already in progress.
    if (INITIALIZE) begin
      w_state_nxt   = ST_CLEAR;
      w_counter_nxt = '0;
    end
  end

endmodule
